arith_pipe_unit: RTL and testbench
==================================

Name: arith_pipe_unit

Overview:
- Parametrised, pipelined successor to the flat 8-bit doubler datapath (o = i + i) used in the generated arithmetic test hierarchy.
- Generalises width and latency and adds operation select: add, subtract, double, accumulate.
- Adds a running accumulator and valid/ready flow control, so it can sit between handshaked producer/consumer blocks in generated datapaths.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2)
- STAGES, 2, pipeline depth in register stages (>= 1); equals accept-to-output latency

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  producer has an operation
- in_ready  output  1  unit accepts this cycle
- op  input  2  0=ADD a+b, 1=SUB a-b, 2=DBL a+a, 3=ACC acc+a
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (ignored for DBL, ACC)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  WIDTH  low WIDTH bits of operation
- carry  output  1  ADD/DBL/ACC: carry-out bit WIDTH; SUB: borrow (a < b unsigned)
- acc_out  output  WIDTH  current accumulator value

Behaviour:
- Reset: synchronous, active-high. On a clk edge with reset=1: all stage valid bits=0, acc=0, out_valid=0, result=0, carry=0, acc_out=0. in_ready is 1 in the cycle after reset deasserts. Reset mid-operation discards all in-flight entries; acc goes to 0.
- Accept: transfer happens when in_valid && in_ready at the clk edge. out_valid/out_ready transfer follows the same rule.
- Arithmetic: computed at accept time, at full width WIDTH+1, unsigned.
  - ADD: {carry,result} = a + b
  - SUB: {borrow,result} = {0,a} - {0,b}; carry = borrow
  - DBL: {carry,result} = a + a
  - ACC: {carry,result} = acc + a; acc <= result (truncated); wraps modulo 2^WIDTH
- acc changes only on an accepted ACC; other ops leave it unchanged. acc_out is registered and shows the value after the last accepted ACC.
- Back-to-back ACC: each uses the acc updated by the previous accepted ACC (no hazard, because the update is at accept).
- Pipeline: STAGES registered stages, each holding {valid, result, carry}.
  - Stage 0 loads on accept. Stage k loads from stage k-1.
  - Stage k advances iff stage k+1 is empty or advances; the last stage advances iff out_valid=0 or out_ready=1.
- in_ready = stage0 empty OR stage0 advances (bubble-collapsing; combinational from out_ready through the stage chain).
- out_valid/result/carry are driven directly from the last stage.
- Latency: with no stall, an accept at edge N gives out_valid=1 after edge N+STAGES-1 (STAGES=1: out_valid in the cycle after accept).
- Throughput: one op per cycle while out_ready=1.
- Full: all stages valid and out_ready=0 -> in_ready=0. The held result must stay stable with no loss or duplication.
- Simultaneous accept and output on a full pipe is allowed (in_ready=1 when out_ready=1).
- in_valid with in_ready=0: no state change, acc unchanged.

Decomposition:
- Shared package arith_pkg:
  - op encodings OP_ADD/OP_SUB/OP_DBL/OP_ACC
  - typedef op_t (2 bits)
  - stage-record struct {valid, carry, result} parameterised by width via a macro/function
- Sub-module arith_core: combinational WIDTH+1 compute of op, a, b, acc -> {carry,result}. Natural successor of the old adder leaf.
- Pipeline, handshake and acc register live in arith_pipe_unit.

Test Plan (WIDTH=8, STAGES=2):
- Reset, then DBL a=0x41, out_ready=1 -> out_valid=1 two edges after accept with result=0x82, carry=0; then DBL a=0x80 -> result=0x00, carry=1.
- SUB a=0x05 b=0x07 -> result=0xFE, carry=1. ADD a=0xFF b=0x01 -> result=0x00, carry=1.
- ACC a=0x10, 0x20, 0xF0 back-to-back -> results 0x10, 0x30, 0x20 (last has carry=1); acc_out=0x20; an interleaved ADD leaves acc unchanged.
- out_ready=0 with 4 ops streamed -> in_ready drops after 2 accepts; then out_ready=1 -> all 4 results in order, none dropped or duplicated, one per cycle.
- Reset asserted for one cycle with 2 ops in flight and acc=0x30 -> out_valid=0, acc_out=0 next cycle; the next ACC a=0x01 yields 0x01.
- Random stream with random out_ready for 1000 ops, checked against a reference model -> exact match of order, result and carry.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared op encodings and the per-stage record used by the arithmetic pipeline.
`ifndef ARITH_PKG_SV
`define ARITH_PKG_SV

// Stage record {valid, carry, result}; a macro because package types cannot take a width parameter.
`define ARITH_STAGE_T(W) struct packed { logic valid; logic carry; logic [(W)-1:0] result; }

package arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_DBL = 2'd2,
        OP_ACC = 2'd3
    } op_t;

    localparam int OP_W = 2;

endpackage

`endif

// File: rtl/arith_core.sv
// Combinational WIDTH+1 bit compute of one operation; successor of the flat doubler leaf.
module arith_core
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_acc,
    output logic [WIDTH:0]   o_sum
);

    logic [WIDTH:0] w_sum;

    // For SUB the top bit of the widened difference is the unsigned borrow.
    always_comb begin
        w_sum = '0;
        case (op_t'(i_op))
            OP_ADD:  w_sum = {1'b0, i_a} + {1'b0, i_b};
            OP_SUB:  w_sum = {1'b0, i_a} - {1'b0, i_b};
            OP_DBL:  w_sum = {1'b0, i_a} + {1'b0, i_a};
            OP_ACC:  w_sum = {1'b0, i_acc} + {1'b0, i_a};
            default: w_sum = '0;
        endcase
    end

    assign o_sum = w_sum;

endmodule

// File: rtl/arith_pipe_unit.sv
// Pipelined add/sub/double/accumulate unit with valid/ready on both sides.
module arith_pipe_unit
    import arith_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic [WIDTH-1:0] acc_out
);

    typedef `ARITH_STAGE_T(WIDTH) stage_t;

    stage_t              r_stg [STAGES];
    logic [WIDTH-1:0]    r_acc;
    logic [STAGES-1:0]   w_vld;
    logic [STAGES-1:0]   w_en;
    logic [WIDTH:0]      w_sum;
    logic                w_accept;

    arith_core #(.WIDTH(WIDTH)) u_core (
        .i_op  (op),
        .i_a   (a),
        .i_b   (b),
        .i_acc (r_acc),
        .o_sum (w_sum)
    );

    // Stage k may load when the consumer takes or any stage at or after k is empty;
    // flattened form of the ripple so there is no self-referencing bit chain.
    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_stage
            assign w_vld[g] = r_stg[g].valid;
            assign w_en[g]  = out_ready | ~(&w_vld[STAGES-1:g]);
        end
    endgenerate

    assign in_ready = w_en[0];
    assign w_accept = in_valid & w_en[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) r_stg[k] <= '0;
            r_acc <= '0;
        end else begin
            if (w_en[0])
                r_stg[0] <= '{valid: w_accept, carry: w_sum[WIDTH], result: w_sum[WIDTH-1:0]};
            for (int k = 1; k < STAGES; k++)
                if (w_en[k]) r_stg[k] <= r_stg[k-1];
            // Updating at accept lets back-to-back ACCs chain without a hazard.
            if (w_accept && op_t'(op) == OP_ACC)
                r_acc <= w_sum[WIDTH-1:0];
        end
    end

    assign out_valid = r_stg[STAGES-1].valid;
    assign result    = r_stg[STAGES-1].result;
    assign carry     = r_stg[STAGES-1].carry;
    assign acc_out   = r_acc;

endmodule

// File: tb/tb_arith_pipe_unit.sv
// Self-checking bench for arith_pipe_unit (WIDTH=8, STAGES=2) with a behavioural reference model.
module tb_arith_pipe_unit;

    localparam int W = 8;
    localparam int S = 2;
    localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, DBL = 2'd2, ACC = 2'd3;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic [W-1:0] acc_out;

    int n_checks = 0;
    int n_pass   = 0;

    arith_pipe_unit #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .acc_out   (acc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {carry/borrow, result} from plain integer arithmetic.
    function automatic logic [8:0] model(input logic [1:0] o, input int x, input int y, input int acc);
        int s;
        case (o)
            ADD:     s = x + y;
            SUB:     s = (x >= y) ? (x - y) : (x - y + 256 + 256);
            DBL:     s = 2 * x;
            default: s = acc + x;
        endcase
        return 9'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = ADD; a = '0; b = '0;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    // Pushes one op through with out_ready=1 and returns the first result seen.
    task automatic run_one(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                           output logic [8:0] r, output bit ok);
        bit took;
        ok = 1'b0; r = '0; took = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; op = o; a = x; b = y;
        for (int i = 0; i < 20 && !took; i++) begin
            #1 took = in_ready;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (out_valid) begin
                r = {carry, result}; ok = 1'b1;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset(2);
        reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (result !== 8'h00) $display("FAIL reset_result: got %h exp 00", result); else n_pass++;
        n_checks++; if (carry !== 1'b0) $display("FAIL reset_carry: got %b exp 0", carry); else n_pass++;
        n_checks++; if (acc_out !== 8'h00) $display("FAIL reset_acc: got %h exp 00", acc_out); else n_pass++;
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b exp 1", in_ready); else n_pass++;
    endtask

    task automatic test_dbl();
        logic [8:0] r;
        bit ok;
        out_ready = 1'b1; in_valid = 1'b1; op = DBL; a = 8'h41; b = 8'h00;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL dbl_in_ready: got %b exp 1", in_ready); else n_pass++;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL dbl_early_valid: got %b exp 0", out_valid); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL dbl_latency_valid: got %b exp 1", out_valid); else n_pass++;
        n_checks++; if ({carry, result} !== 9'h082) $display("FAIL dbl_41: got %h exp 082", {carry, result}); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL dbl_no_dup: got %b exp 0", out_valid); else n_pass++;
        run_one(DBL, 8'h80, 8'h00, r, ok);
        n_checks++; if (!ok || r !== 9'h100) $display("FAIL dbl_80: got %h ok %b exp 100", r, ok); else n_pass++;
    endtask

    task automatic test_add_sub();
        logic [8:0] r;
        bit ok;
        logic [7:0] x, y;
        run_one(SUB, 8'h05, 8'h07, r, ok);
        n_checks++; if (!ok || r !== 9'h1FE) $display("FAIL sub_05_07: got %h ok %b exp 1fe", r, ok); else n_pass++;
        run_one(ADD, 8'hFF, 8'h01, r, ok);
        n_checks++; if (!ok || r !== 9'h100) $display("FAIL add_ff_01: got %h ok %b exp 100", r, ok); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            x = 8'($urandom); y = 8'($urandom);
            run_one((i % 2 == 0) ? ADD : SUB, x, y, r, ok);
            n_checks++;
            if (!ok || r !== model((i % 2 == 0) ? ADD : SUB, int'(x), int'(y), 0))
                $display("FAIL addsub_rand: op %0d a %h b %h got %h exp %h", i % 2, x, y, r,
                         model((i % 2 == 0) ? ADD : SUB, int'(x), int'(y), 0));
            else n_pass++;
        end
    endtask

    task automatic test_acc();
        logic [1:0] t_op [4];
        logic [7:0] t_a [4];
        logic [7:0] t_b [4];
        logic [8:0] expv [4];
        logic [8:0] got [$];
        do_reset(1);
        t_op = '{ACC, ACC, ADD, ACC};
        t_a  = '{8'h10, 8'h20, 8'h01, 8'hF0};
        t_b  = '{8'h00, 8'h00, 8'h02, 8'h00};
        expv = '{9'h010, 9'h030, 9'h003, 9'h120};
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 4);
            if (c < 4) begin op = t_op[c]; a = t_a[c]; b = t_b[c]; end
            #1;
            if (out_valid) got.push_back({carry, result});
            tick();
            if (c == 0) begin
                n_checks++; if (acc_out !== 8'h10) $display("FAIL acc_after_first: got %h exp 10", acc_out); else n_pass++;
            end
            if (c == 2) begin
                n_checks++; if (acc_out !== 8'h30) $display("FAIL acc_add_keeps: got %h exp 30", acc_out); else n_pass++;
            end
        end
        n_checks++; if (got.size() !== 4) $display("FAIL acc_count: got %0d exp 4", got.size()); else n_pass++;
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== expv[i]) $display("FAIL acc_seq[%0d]: got %h exp %h", i, got[i], expv[i]); else n_pass++;
        end
        n_checks++; if (acc_out !== 8'h20) $display("FAIL acc_final: got %h exp 20", acc_out); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] t_op [4];
        logic [7:0] t_a [4];
        logic [7:0] t_b [4];
        logic [8:0] expv [4];
        logic [8:0] got [$];
        int sent = 0, first = -1, last = -1;
        bit rdy, hold_bad = 1'b0;
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            t_op[i] = 2'($urandom_range(0, 2)); t_a[i] = 8'($urandom); t_b[i] = 8'($urandom);
            expv[i] = model(t_op[i], int'(t_a[i]), int'(t_b[i]), 0);
        end
        for (int c = 0; c < 20; c++) begin
            out_ready = (c >= 6);
            in_valid  = (sent < 4);
            if (sent < 4) begin op = t_op[sent]; a = t_a[sent]; b = t_b[sent]; end
            #1;
            rdy = in_ready;
            if (c >= 2 && c < 6 && (out_valid !== 1'b1 || {carry, result} !== expv[0])) hold_bad = 1'b1;
            if (c == 5) begin
                n_checks++; if (sent !== 2) $display("FAIL stall_accepts: got %0d exp 2", sent); else n_pass++;
                n_checks++; if (rdy !== 1'b0) $display("FAIL stall_in_ready: got %b exp 0", rdy); else n_pass++;
            end
            if (out_valid && out_ready) begin
                got.push_back({carry, result});
                if (first < 0) first = c;
                last = c;
            end
            tick();
            if (in_valid && rdy) sent++;
        end
        in_valid = 1'b0;
        n_checks++; if (hold_bad) $display("FAIL stall_hold: got unstable exp %h held", expv[0]); else n_pass++;
        n_checks++; if (got.size() !== 4) $display("FAIL stall_count: got %0d exp 4", got.size()); else n_pass++;
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== expv[i]) $display("FAIL stall_seq[%0d]: got %h exp %h", i, got[i], expv[i]); else n_pass++;
        end
        n_checks++; if (last - first !== 3) $display("FAIL stall_rate: got span %0d exp 3", last - first); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [8:0] r;
        bit ok;
        do_reset(1);
        run_one(ACC, 8'h10, 8'h00, r, ok);
        run_one(ACC, 8'h20, 8'h00, r, ok);
        n_checks++; if (acc_out !== 8'h30) $display("FAIL mid_acc_setup: got %h exp 30", acc_out); else n_pass++;
        out_ready = 1'b0; in_valid = 1'b1; op = ADD; a = 8'h01; b = 8'h01;
        tick();
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL mid_inflight: got %b exp 1", out_valid); else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (acc_out !== 8'h00) $display("FAIL mid_acc: got %h exp 00", acc_out); else n_pass++;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b exp 1", in_ready); else n_pass++;
        run_one(ACC, 8'h01, 8'h00, r, ok);
        n_checks++; if (!ok || r !== 9'h001) $display("FAIL mid_acc_next: got %h ok %b exp 001", r, ok); else n_pass++;
    endtask

    task automatic test_random();
        logic [8:0] q [$];
        logic [8:0] e;
        int m_acc = 0, sent = 0, cyc = 0;
        bit pend = 1'b0, rdy, acc_hit;
        do_reset(1);
        while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
            if (!pend && sent < 1000 && $urandom_range(0, 9) < 7) begin
                pend = 1'b1; op = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
            end
            in_valid  = pend;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            rdy = in_ready;
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) $display("FAIL rand_extra: got %h exp none", {carry, result});
                else begin
                    e = q.pop_front();
                    if ({carry, result} !== e) $display("FAIL rand_result: got %h exp %h", {carry, result}, e);
                    else n_pass++;
                end
            end
            acc_hit = 1'b0;
            if (pend && rdy) begin
                q.push_back(model(op, int'(a), int'(b), m_acc));
                if (op == ACC) begin m_acc = (m_acc + int'(a)) % 256; acc_hit = 1'b1; end
                pend = 1'b0; sent++;
            end
            tick();
            cyc++;
            if (acc_hit) begin
                n_checks++; if (acc_out !== 8'(m_acc)) $display("FAIL rand_acc: got %h exp %h", acc_out, 8'(m_acc)); else n_pass++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (cyc >= 20000) $display("FAIL rand_timeout: got %0d sent %0d pending exp done", sent, q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_dbl();
        test_add_sub();
        test_acc();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
